// File: rtl/longest_run_tracker.sv
// Measures the longest run of consecutive 1 bits (MSB first) across a framed byte stream.
// Result is presented one cycle after the last byte and held until out_ready; input stalls meanwhile.
module longest_run_tracker #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic          in_first,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_maxrun,
  output logic [CW-1:0] out_bytes,
  output logic          err_restart
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [CW-1:0] SAT = '1;

  logic [1:0]    state;
  logic [CW-1:0] carry, maxrun, bytes;
  logic          take;
  logic [CW-1:0] base_carry, base_max, base_bytes;
  logic [CW-1:0] cand, nxt_carry, nxt_max, nxt_bytes;

  function automatic logic [3:0] lead_ones(input logic [7:0] d);
    logic [3:0] n;
    logic       stop;
    n    = 4'd0;
    stop = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (!d[i]) stop = 1'b1;
      else if (!stop) n = n + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [3:0] trail_ones(input logic [7:0] d);
    logic [3:0] n;
    logic       stop;
    n    = 4'd0;
    stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!d[i]) stop = 1'b1;
      else if (!stop) n = n + 4'd1;
    end
    return n;
  endfunction

  function automatic logic [3:0] inner_run(input logic [7:0] d);
    logic [3:0] run, best;
    run  = 4'd0;
    best = 4'd0;
    for (int i = 0; i < 8; i++) begin
      run = d[i] ? run + 4'd1 : 4'd0;
      if (run > best) best = run;
    end
    return best;
  endfunction

  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW] ? SAT : s[CW-1:0];
  endfunction

  function automatic logic [CW-1:0] max2(input logic [CW-1:0] a, input logic [CW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign in_ready    = reset_n && (state != DONE);
  assign out_valid   = (state == DONE);
  assign out_maxrun  = maxrun;
  assign out_bytes   = bytes;

  // In IDLE only a first byte opens a frame; other bytes are swallowed without effect.
  always_comb begin
    take       = in_valid && in_ready && ((state == ACCUM) || in_first);
    base_carry = in_first ? '0 : carry;
    base_max   = in_first ? '0 : maxrun;
    base_bytes = in_first ? '0 : bytes;
    if (in_data == 8'hFF) begin
      cand      = sat_add(base_carry, CW'(8));
      nxt_carry = cand;
    end else begin
      cand      = max2(sat_add(base_carry, CW'(lead_ones(in_data))), CW'(inner_run(in_data)));
      nxt_carry = CW'(trail_ones(in_data));
    end
    nxt_max   = max2(base_max, cand);
    nxt_bytes = sat_add(base_bytes, CW'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      carry       <= '0;
      maxrun      <= '0;
      bytes       <= '0;
      err_restart <= 1'b0;
    end else begin
      err_restart <= take && in_first && (state == ACCUM);
      if (take) begin
        carry  <= nxt_carry;
        maxrun <= nxt_max;
        bytes  <= nxt_bytes;
        state  <= in_last ? DONE : ACCUM;
      end else if ((state == DONE) && out_ready) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_longest_run_tracker.sv
// Scoreboard bench for longest_run_tracker: default-width and CW=4 instances share one stimulus stream.
module tb_longest_run_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, in_first, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, err_restart;
  logic [11:0] out_maxrun, out_bytes;
  logic        in_ready4, out_valid4, err_restart4;
  logic [3:0]  out_maxrun4, out_bytes4;

  longest_run_tracker dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_maxrun(out_maxrun),
    .out_bytes(out_bytes), .err_restart(err_restart)
  );

  longest_run_tracker #(.CW(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid4), .out_ready(out_ready), .out_maxrun(out_maxrun4),
    .out_bytes(out_bytes4), .err_restart(err_restart4)
  );

  typedef struct {
    int mr;
    int nb;
    int mr4;
    int nb4;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] frame_q[$];
  bit         in_frame = 0;
  int         checks = 0;
  int         errors = 0;

  // Bit-serial reference: walk the frame MSB first, saturating the running count.
  function automatic int model_run(input int lim);
    int run, best;
    run  = 0;
    best = 0;
    foreach (frame_q[k]) begin
      for (int b = 7; b >= 0; b--) begin
        if (frame_q[k][b]) begin
          if (run < lim) run++;
        end else begin
          run = 0;
        end
        if (run > best) best = run;
      end
    end
    return best;
  endfunction

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic send_byte(input logic [7:0] d, input bit f, input bit l, output int waits);
    exp_t e;
    in_valid = 1'b1;
    in_data  = d;
    in_first = f;
    in_last  = l;
    waits    = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (f) begin
      frame_q.delete();
      in_frame = 1;
    end
    if (in_frame) begin
      frame_q.push_back(d);
      if (l) begin
        e.mr  = model_run(4095);
        e.nb  = sat(frame_q.size(), 4095);
        e.mr4 = model_run(15);
        e.nb4 = sat(frame_q.size(), 15);
        sb.push_back(e);
        frame_q.delete();
        in_frame = 0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take_result(output logic [31:0] mr, output logic [31:0] nb,
                             output logic [31:0] mr4, output logic [31:0] nb4, output bit ok);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok  = (out_valid === 1'b1) && (out_valid4 === 1'b1);
    mr  = 32'(out_maxrun);
    nb  = 32'(out_bytes);
    mr4 = 32'(out_maxrun4);
    nb4 = 32'(out_bytes4);
    if (ok) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    e = '{-1, -1, -1, -1};
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  logic [31:0] mr, nb, mr4, nb4;
  bit          ok;
  exp_t        e;
  int          w;

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = 8'h00; out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || in_ready4 !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b/%b required 0", in_ready, in_ready4);
    end
    checks++;
    if (out_valid !== 1'b0 || out_maxrun !== 12'd0 || out_bytes !== 12'd0 || err_restart !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b mr=%0d nb=%0d err=%b required all 0",
               out_valid, out_maxrun, out_bytes, err_restart);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready got %b required 1", in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    send_byte(8'h6E, 1, 1, w);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL single_latency out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL single_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
  endtask

  task automatic test_boundary();
    send_byte(8'h0F, 1, 0, w);
    send_byte(8'hF0, 0, 1, w);
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL boundary_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
  endtask

  task automatic test_saturate();
    send_byte(8'hFF, 1, 0, w);
    send_byte(8'hFF, 0, 0, w);
    send_byte(8'hFF, 0, 0, w);
    send_byte(8'h00, 0, 1, w);
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL sat_ff3_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
    for (int i = 0; i < 17; i++) send_byte(8'hFF, i == 0, i == 16, w);
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL sat_ff17_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
  endtask

  task automatic test_stall();
    logic [11:0] hold_mr, hold_nb;
    send_byte(8'h55, 1, 1, w);
    hold_mr  = out_maxrun;
    hold_nb  = out_bytes;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'hAA; in_first = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_maxrun !== hold_mr || out_bytes !== hold_nb) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got v=%b rdy=%b mr=%0d nb=%0d required v=1 rdy=0 mr=%0d nb=%0d",
                 i, out_valid, in_ready, out_maxrun, out_bytes, hold_mr, hold_nb);
      end
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL stall_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
  endtask

  task automatic test_restart();
    send_byte(8'hFF, 1, 0, w);
    checks++;
    if (err_restart !== 1'b0) begin
      errors++; $display("FAIL restart_no_pulse_on_open got %b required 0", err_restart);
    end
    send_byte(8'h01, 1, 1, w);
    checks++;
    if (err_restart !== 1'b1 || err_restart4 !== 1'b1) begin
      errors++; $display("FAIL restart_pulse got %b/%b required 1", err_restart, err_restart4);
    end
    @(negedge clk);
    checks++;
    if (err_restart !== 1'b0) begin
      errors++; $display("FAIL restart_pulse_width got %b required 0", err_restart);
    end
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL restart_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h0F, 1, 0, w);
    send_byte(8'hFF, 0, 0, w);
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_maxrun !== 12'd0 || out_bytes !== 12'd0) begin
      errors++;
      $display("FAIL midreset_outputs got rdy=%b v=%b mr=%0d nb=%0d required 0", in_ready, out_valid, out_maxrun, out_bytes);
    end
    frame_q.delete();
    in_frame = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_byte(8'h00, 1, 1, w);
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL midreset_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL midreset_stale out_valid=%b pending=%0d required 0/0", out_valid, sb.size());
    end
  endtask

  task automatic test_discard_ignore();
    send_byte(8'hFF, 0, 0, w);
    send_byte(8'hE0, 1, 0, w);
    in_first = 1'b1;
    in_last  = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL ignore_last_when_invalid out_valid=%b required 0", out_valid);
      end
    end
    in_first = 1'b0;
    in_last  = 1'b0;
    send_byte(8'h07, 0, 1, w);
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL discard_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h3C, 1, 1, w);
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL b2b_first_result got ok=%0b mr=%0d nb=%0d required mr=%0d nb=%0d", ok, mr, nb, e.mr, e.nb);
    end
    send_byte(8'h81, 1, 0, w);
    checks++;
    if (w != 0) begin
      errors++; $display("FAIL b2b_bubble wait cycles=%0d required 0", w);
    end
    send_byte(8'h81, 0, 1, w);
    take_result(mr, nb, mr4, nb4, ok);
    e = pop_exp();
    checks++;
    if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
      errors++;
      $display("FAIL b2b_second_result got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
               ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
    end
  endtask

  task automatic test_random();
    int len, dly;
    logic [7:0] d;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        d = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        send_byte(d, i == 0, i == len - 1, w);
      end
      dly = $urandom_range(0, 3);
      for (int i = 0; i < dly; i++) @(negedge clk);
      take_result(mr, nb, mr4, nb4, ok);
      e = pop_exp();
      checks++;
      if (!ok || mr !== e.mr || nb !== e.nb || mr4 !== e.mr4 || nb4 !== e.nb4) begin
        errors++;
        $display("FAIL random_frame %0d got ok=%0b mr=%0d nb=%0d mr4=%0d nb4=%0d required mr=%0d nb=%0d mr4=%0d nb4=%0d",
                 f, ok, mr, nb, mr4, nb4, e.mr, e.nb, e.mr4, e.nb4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_saturate();
    test_stall();
    test_restart();
    test_reset_midframe();
    test_discard_ignore();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/longest_run_tracker.md
LONGEST_RUN_TRACKER -- requirements
Module: longest_run_tracker

Interface
REQ-001 SHALL have parameter CW, default 12, giving the width of the run and byte counters.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, which flags in_data, in_first and in_last as valid.
REQ-005 SHALL have port in_ready, output, 1; a byte transfers when in_valid and in_ready are both high.
REQ-006 SHALL have port in_data, input, 8, one stream byte; bit 7 is earliest in the bit stream.
REQ-007 SHALL have port in_first, input, 1, marking the first byte of a frame.
REQ-008 SHALL have port in_last, input, 1, marking the last byte of a frame.
REQ-009 SHALL have port out_valid, output, 1, meaning the frame result is valid.
REQ-010 SHALL have port out_ready, input, 1; the result transfers when out_valid and out_ready are both high.
REQ-011 SHALL have port out_maxrun, output, CW, the longest run of consecutive 1 bits in the frame, including runs that span byte boundaries.
REQ-012 SHALL have port out_bytes, output, CW, the number of bytes in the frame.
REQ-013 SHALL have port err_restart, output, 1, a one-cycle pulse when a frame is restarted by in_first.

Function
REQ-014 SHALL use an FSM with states IDLE, ACCUM and DONE; in_ready = 1 in IDLE and ACCUM, 0 in DONE.
REQ-015 SHALL, per accepted byte, form combinationally:
- lead = number of leading 1s counted from bit 7;
- trail = number of trailing 1s counted from bit 0;
- inner = longest run of 1s within the byte (0..8).
REQ-016 SHALL keep a carry register holding the length of the 1-run ending at the last accepted bit.
REQ-017 SHALL, for a byte equal to 0xFF, set cand = carry+8 and the new carry = carry+8.
REQ-018 SHALL, for any other byte, set cand = max(carry+lead, inner) and the new carry = trail.
REQ-019 SHALL set maxrun = max(maxrun, cand) on each accepted byte.
REQ-020 SHALL saturate all arithmetic at 2^CW-1 (carry, maxrun, byte count); there is no wrap-around.
REQ-021 SHALL, on an in_first byte accepted in IDLE, start a frame with carry = 0, maxrun = 0, bytes = 0, then process the byte.
- The FSM goes to DONE if in_last is set, otherwise to ACCUM.
REQ-022 SHALL accept and discard bytes accepted in IDLE without in_first; state is unchanged.
REQ-023 SHALL, in ACCUM, process each accepted byte and go to DONE when in_last is set.
REQ-024 SHALL, when a byte with in_first is accepted in ACCUM, discard the partial frame and restart the frame with that byte as in REQ-021.
- err_restart SHALL be high for exactly the following cycle.
REQ-025 SHALL, in DONE, assert out_valid with out_maxrun and out_bytes held stable until the out_ready handshake, then return to IDLE.
REQ-026 SHALL assert out_valid in the cycle after the last-byte handshake (1-cycle latency).
REQ-027 SHALL allow a new frame byte to be accepted in the cycle after the result handshake, with no extra bubble.
REQ-028 SHALL ignore in_first and in_last when in_valid is low.

Reset
REQ-029 SHALL, while reset_n is low, immediately force the following, regardless of clk:
- state = IDLE;
- carry, maxrun and bytes counters = 0;
- out_valid = 0, out_maxrun = 0, out_bytes = 0, err_restart = 0;
- in_ready = 0.
REQ-030 SHALL drive in_ready = 1 in the first cycle after reset_n is released.
REQ-031 SHALL lose any in-progress frame or pending result on reset; nothing from it is output.

Verification
REQ-032 SHALL cover a single byte 0x6E with first and last set -> next cycle out_valid = 1, out_maxrun = 3, out_bytes = 1.
REQ-033 SHALL cover the frame 0x0F, 0xF0 -> out_maxrun = 8, out_bytes = 2 (run across the boundary).
REQ-034 SHALL cover the frame 0xFF, 0xFF, 0xFF, 0x00 -> out_maxrun = 24, out_bytes = 4; the same frame with CW = 4 -> out_maxrun = 15, out_bytes = 4.
REQ-035 SHALL cover out_ready held low for 5 cycles in DONE -> out_valid held high, outputs stable, in_ready = 0, and no bytes accepted.
REQ-036 SHALL cover 0xFF (first), then 0x01 (first, last) -> err_restart pulses once, then out_maxrun = 1, out_bytes = 1.
REQ-037 SHALL cover reset_n pulsed low mid-frame, then 0x00 (first, last) -> out_maxrun = 0, out_bytes = 1, and no stale result appears.
